// File: rtl/load_store_unit.sv
// Load/store unit: drives a single-port word RAM with a registered read, doing lane
// extraction/extension on loads and read-modify-write on SB/SH. Optional range check: LSU_BOUNDS_CHECK_EN.
module load_store_unit #(
  parameter int DEPTH_WORDS = 2048
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        mem_write_enable_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i
);

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, DONE} state_t;

  state_t      state;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic        misaligned;
  logic        illegal;
  logic        range_err;
  logic        req_err;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_value;
  logic [31:0] merged;

  always_comb begin
    misaligned = 1'b0;
    illegal    = 1'b0;
    if (we_i) begin
      case (funct3_i)
        3'd0:    misaligned = 1'b0;
        3'd1:    misaligned = addr_i[0];
        3'd2:    misaligned = |addr_i[1:0];
        default: illegal = 1'b1;
      endcase
    end else begin
      case (funct3_i)
        3'd0, 3'd4: misaligned = 1'b0;
        3'd1, 3'd5: misaligned = addr_i[0];
        3'd2:       misaligned = |addr_i[1:0];
        default:    illegal = 1'b1;
      endcase
    end
  end

`ifdef LSU_BOUNDS_CHECK_EN
  assign range_err = ({2'b00, addr_i[31:2]} >= 32'(DEPTH_WORDS));
`else
  // Without the check the depth is irrelevant; out-of-range indices go straight to the RAM.
  logic unused_range;
  assign unused_range = ({2'b00, addr_i[31:2]} >= 32'(DEPTH_WORDS));
  assign range_err    = 1'b0;
`endif

  assign req_err = misaligned | illegal | range_err;

  always_comb begin
    sel_byte = mem_data_i[{lane_q, 3'b000} +: 8];
    sel_half = lane_q[1] ? mem_data_i[31:16] : mem_data_i[15:0];
    case (funct3_q)
      3'd0:    load_value = {{24{sel_byte[7]}}, sel_byte};
      3'd1:    load_value = {{16{sel_half[15]}}, sel_half};
      3'd4:    load_value = {24'd0, sel_byte};
      3'd5:    load_value = {16'd0, sel_half};
      default: load_value = mem_data_i;
    endcase
    merged = mem_data_i;
    if (funct3_q[1:0] == 2'd0)
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
  end

  // All outputs are registered so the RAM-side signals only move on clock edges or reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state              <= IDLE;
      we_q               <= 1'b0;
      funct3_q           <= 3'd0;
      lane_q             <= 2'd0;
      wdata_q            <= 16'd0;
      rdata_o            <= 32'd0;
      done_o             <= 1'b0;
      err_o              <= 1'b0;
      busy_o             <= 1'b0;
      mem_write_enable_o <= 1'b0;
      mem_address_o      <= 32'd0;
      mem_data_o         <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            we_q     <= we_i;
            funct3_q <= funct3_i;
            lane_q   <= addr_i[1:0];
            wdata_q  <= wdata_i[15:0];
            busy_o   <= 1'b1;
            if (req_err) begin
              done_o <= 1'b1;
              err_o  <= 1'b1;
              state  <= DONE;
            end else if (we_i && funct3_i == 3'd2) begin
              mem_address_o      <= {2'b00, addr_i[31:2]};
              mem_data_o         <= wdata_i;
              mem_write_enable_o <= 1'b1;
              state              <= WRITE;
            end else begin
              mem_address_o <= {2'b00, addr_i[31:2]};
              state         <= READ;
            end
          end
        end
        READ: state <= CAPTURE;
        CAPTURE: begin
          if (we_q) begin
            mem_data_o         <= merged;
            mem_write_enable_o <= 1'b1;
            state              <= WRITE;
          end else begin
            rdata_o <= load_value;
            done_o  <= 1'b1;
            state   <= DONE;
          end
        end
        WRITE: begin
          mem_write_enable_o <= 1'b0;
          done_o             <= 1'b1;
          state              <= DONE;
        end
        DONE: begin
          done_o <= 1'b0;
          err_o  <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-side initiator for the softcore: accepts one load or store per request from the execute stage and drives the single-port word-addressed data RAM. The RAM has a word-wide write enable and a registered 1-cycle read that is suppressed during writes, so the block performs byte/halfword extraction and sign/zero extension on loads, and read-modify-write for sub-word stores. It sits between the execute stage and the data RAM, and reports completion, load data and alignment/range errors back to the core.

## Interface
- DEPTH_WORDS, 2048: RAM depth in 32-bit words; used only by the bounds check.
- clk_i  input  1  clock; all state changes on rising edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- req_i  input  1  request strobe; sampled only when busy_o=0.
- we_i  input  1  1=store, 0=load.
- funct3_i  input  3  RV32I funct3: loads 0=LB, 1=LH, 2=LW, 4=LBU, 5=LHU; stores 0=SB, 1=SH, 2=SW.
- addr_i  input  32  byte address.
- wdata_i  input  32  store data; low byte/halfword used for SB/SH.
- rdata_o  output  32  extended load result; held until the next load completes.
- done_o  output  1  one-cycle completion pulse.
- err_o  output  1  valid with done_o: misaligned, illegal funct3, or out of range.
- busy_o  output  1  high whenever the FSM is not IDLE.
- mem_write_enable_o  output  1  RAM write enable.
- mem_address_o  output  32  RAM word index, addr[31:2] zero-extended.
- mem_data_o  output  32  RAM write data.
- mem_data_i  input  32  RAM registered read data.

## Operation
- States: IDLE, READ, CAPTURE, WRITE, DONE.
- IDLE: on req_i, latch we_i, funct3_i, addr_i and wdata_i.
  - Error (misaligned, illegal funct3, or range violation): go to DONE with err latched; the RAM is never touched.
  - SW: go to WRITE.
  - Any load, SB or SH: go to READ.
- Error conditions:
  - Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0.
  - Illegal funct3: loads 3, 6, 7; stores 3–7.
- READ: mem_write_enable_o=0, mem_address_o=word index. Go to CAPTURE.
- CAPTURE: mem_data_i is valid.
  - Load: select the lane little-endian (byte lane addr[1:0], halfword lane addr[1]), sign-extend for LB/LH or zero-extend for LBU/LHU, register into rdata_o, go to DONE.
  - SB/SH: merge wdata into the selected lane of mem_data_i, register into mem_data_o, go to WRITE.
- WRITE: mem_write_enable_o=1 for exactly one cycle. mem_data_o = wdata_i (SW) or the merged word. Go to DONE.
- DONE: done_o=1, err_o = latched error. Go to IDLE.
- req_i while busy_o=1 is ignored; no queueing.
- rdata_o is updated only by successful loads; stores and errors leave it unchanged.

## Timing
- Request accepted in cycle N (IDLE, req_i=1).
- Latency to done_o:
  - Load: READ N+1, CAPTURE N+2, done_o at N+3.
  - SW: WRITE N+1, done_o at N+2.
  - SB/SH: READ N+1, CAPTURE N+2, WRITE N+3, done_o at N+4.
  - Error: done_o at N+1.
- A new request is accepted no earlier than the cycle after DONE; busy_o is low in that cycle.
- mem_write_enable_o, mem_address_o and mem_data_o are registered; they change only on clock edges or on reset.
- Reset values: state IDLE; rdata_o, done_o, err_o, busy_o, mem_write_enable_o, mem_address_o, mem_data_o all 0.
- Reset asserted mid-operation, including in WRITE: mem_write_enable_o drops immediately (asynchronous), no done_o is produced, and the in-flight access is abandoned. Once rst_n_i deasserts, the first edge samples IDLE.

## Configuration
- LSU_BOUNDS_CHECK_EN defined:
  - Range violation when addr_i[31:2] ≥ DEPTH_WORDS.
  - The violation is an error: done_o and err_o assert at N+1 with no RAM access.
- LSU_BOUNDS_CHECK_EN undefined:
  - No range check.
  - The word index is passed through unchanged; out-of-range behaviour is the RAM's.

## Test plan
- RAM word 0 = 0xFFFFFFFF:
  - LB addr 0x0 → rdata_o=0xFFFFFFFF, done_o at N+3, err_o=0.
  - LBU addr 0x3 → rdata_o=0x000000FF.
- Word 1 = 0xAABBCCDD:
  - SB addr 0x5, wdata 0x00000012 → single write cycle at N+3 with mem_data_o=0xAABB12DD, word index 1.
  - SH addr 0x6, wdata 0x00008001 → mem_data_o=0x8001CCDD.
  - LH addr 0x6 afterward → rdata_o=0xFFFF8001.
- SW addr 0x8, wdata 0xDEADBEEF → mem_write_enable_o high only at N+1 with mem_address_o=2; done_o at N+2.
- Errors (each → done_o=1 and err_o=1 at N+1, mem_write_enable_o never high, rdata_o unchanged):
  - LW addr 0x2.
  - SH addr 0x1.
  - Load funct3=3.
  - With LSU_BOUNDS_CHECK_EN: LW addr 0x2000.
- Back-to-back requests:
  - req_i held high → second request accepted only after DONE.
  - Pulse on req_i while busy → ignored; exactly one done_o observed.
- SB with rst_n_i pulsed low during WRITE → mem_write_enable_o=0 within the reset cycle, no done_o, all outputs 0.
- After that reset, an LW completes normally.
